// File: rtl/qmult_pair_arbiter.sv
// Round-robin arbiter sharing one pair of Q-format sign-magnitude multipliers
// between two clients; each grant yields two products with a vld pulse.
module qmult_pair_arbiter #(
  parameter int N = 32,
  parameter int Q = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] a00,
  input  logic [N-1:0] b00,
  input  logic [N-1:0] a01,
  input  logic [N-1:0] b01,
  input  logic [N-1:0] a10,
  input  logic [N-1:0] b10,
  input  logic [N-1:0] a11,
  input  logic [N-1:0] b11,
  output logic         gnt0,
  output logic         gnt1,
  output logic         vld0,
  output logic         vld1,
  output logic [N-1:0] p0,
  output logic [N-1:0] p1,
  output logic         busy
);

  localparam int MW = N - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic         ptr;     // client that wins a tie
  logic         winner;
  logic         take;
  logic         win;
  logic [N-1:0] opa0;
  logic [N-1:0] opb0;
  logic [N-1:0] opa1;
  logic [N-1:0] opb1;

  // Sign is the XOR of the operand signs even for a zero magnitude;
  // magnitude overflow simply wraps into the low N-1 bits.
  function automatic logic [N-1:0] qmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-3:0] full;
    logic [MW-1:0]  mag;
    full = {{MW{1'b0}}, a[N-2:0]} * {{MW{1'b0}}, b[N-2:0]};
    mag  = MW'(full >> Q);
    return {a[N-1] ^ b[N-1], mag};
  endfunction

  // Handshake: a client holds req with stable operands until its gnt pulse;
  // the cycle after gnt it drops req or presents a new operation. vld follows
  // gnt by exactly one cycle and p0/p1 are meaningful while vld is high.
  always_comb begin
    take       = 1'b0;
    win        = 1'b0;
    state_next = state;
    if (req0 && req1) win = ptr;
    else              win = req1;
    case (state)
      IDLE, RESP: begin
        take       = req0 | req1;
        state_next = take ? MUL : IDLE;
      end
      MUL:     state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      winner <= 1'b0;
      opa0   <= '0;
      opb0   <= '0;
      opa1   <= '0;
      opb1   <= '0;
      p0     <= '0;
      p1     <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        winner <= win;
        ptr    <= ~win;
        opa0   <= win ? a10 : a00;
        opb0   <= win ? b10 : b00;
        opa1   <= win ? a11 : a01;
        opb1   <= win ? b11 : b01;
      end
      if (state == MUL) begin
        p0 <= qmul(opa0, opb0);
        p1 <= qmul(opa1, opb1);
      end
    end
  end

  assign gnt0 = (state == MUL)  && !winner;
  assign gnt1 = (state == MUL)  &&  winner;
  assign vld0 = (state == RESP) && !winner;
  assign vld1 = (state == RESP) &&  winner;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_qmult_pair_arbiter.sv
// Self-checking bench for qmult_pair_arbiter: directed vectors plus randomized
// arbitration checked against a behavioural model.
module tb_qmult_pair_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] a00 = '0, b00 = '0, a01 = '0, b01 = '0;
  logic [31:0] a10 = '0, b10 = '0, a11 = '0, b11 = '0;
  logic        gnt0, gnt1, vld0, vld1, busy;
  logic [31:0] p0, p1;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic        last_w;

  qmult_pair_arbiter #(.N(32), .Q(16)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a00(a00), .b00(b00), .a01(a01), .b01(b01),
    .a10(a10), .b10(b10), .a11(a11), .b11(b11),
    .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
    .p0(p0), .p1(p1), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: sign XOR, magnitude product scaled by 2^16, wrapped to 31 bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, m;
    ma = longint'(a & 32'h7fff_ffff);
    mb = longint'(b & 32'h7fff_ffff);
    m  = (ma * mb) / 65536;
    m  = m % (64'd1 << 31);
    return {a[31] ^ b[31], m[30:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic set_ops0(input logic [31:0] x0, input logic [31:0] y0,
                          input logic [31:0] x1, input logic [31:0] y1);
    a00 = x0; b00 = y0; a01 = x1; b01 = y1;
  endtask

  task automatic set_ops1(input logic [31:0] x0, input logic [31:0] y0,
                          input logic [31:0] x1, input logic [31:0] y1);
    a10 = x0; b10 = y0; a11 = x1; b11 = y1;
  endtask

  task automatic rand_ops0();
    set_ops0($urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic rand_ops1();
    set_ops1($urandom, $urandom, $urandom, $urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req0 = 1'b1;
    set_ops0(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    apply_reset();
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_vld0: got %b want 0", vld0); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL reset_vld1: got %b want 0", vld1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (p0 !== 32'h0) begin errors++; $display("FAIL reset_p0: got %h want 0", p0); end
    checks++; if (p1 !== 32'h0) begin errors++; $display("FAIL reset_p1: got %h want 0", p1); end
  endtask

  task automatic test_single_op();
    set_ops0(32'h001E_0000, 32'h0000_9999, 32'h0001_0000, 32'h0000_4CCC);
    req0 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL single_gnt0: got %b want 1", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt1: got %b want 0", gnt1); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mul: got %b want 1", busy); end
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL single_vld0: got %b want 1", vld0); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL single_vld1: got %b want 0", vld1); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL single_gnt0_drop: got %b want 0", gnt0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_resp: got %b want 1", busy); end
    checks++; if (p0 !== 32'h0011_FFEE) begin errors++; $display("FAIL single_p0: got %h want 0011ffee", p0); end
    checks++; if (p1 !== 32'h0000_4CCC) begin errors++; $display("FAIL single_p1: got %h want 00004ccc", p1); end
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL single_vld0_pulse: got %b want 0", vld0); end
    checks++; if (p0 !== 32'h0011_FFEE) begin errors++; $display("FAIL single_p0_hold: got %h want 0011ffee", p0); end
  endtask

  task automatic test_sign();
    set_ops1(32'h800A_0000, 32'h0000_8000, 32'h8001_0000, 32'h8002_0000);
    req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL sign_gnt1: got %b want 1", gnt1); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL sign_gnt0: got %b want 0", gnt0); end
    req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL sign_vld1: got %b want 1", vld1); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL sign_vld0: got %b want 0", vld0); end
    checks++; if (p0 !== 32'h8005_0000) begin errors++; $display("FAIL sign_p0: got %h want 80050000", p0); end
    checks++; if (p1 !== 32'h0002_0000) begin errors++; $display("FAIL sign_p1: got %h want 00020000", p1); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_overflow();
    set_ops0(32'h0100_0000, 32'h0100_0000, 32'h8000_0000, 32'h0001_0000);
    req0 = 1'b1;
    @(posedge clk); @(negedge clk);
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL ovf_vld0: got %b want 1", vld0); end
    checks++; if (p0 !== 32'h0000_0000) begin errors++; $display("FAIL ovf_p0: got %h want 00000000", p0); end
    checks++; if (p1 !== 32'h8000_0000) begin errors++; $display("FAIL ovf_negzero_p1: got %h want 80000000", p1); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_contention();
    logic [63:0] e;
    apply_reset();
    rand_ops0(); rand_ops1();
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int c;
      c = i % 2;
      @(posedge clk); @(negedge clk);
      checks++; if (gnt0 !== (c == 0)) begin errors++; $display("FAIL cont_gnt0[%0d]: got %b want %b", i, gnt0, c == 0); end
      checks++; if (gnt1 !== (c == 1)) begin errors++; $display("FAIL cont_gnt1[%0d]: got %b want %b", i, gnt1, c == 1); end
      if (c == 0) begin
        exp_q.push_back({ref_mul(a00, b00), ref_mul(a01, b01)});
        rand_ops0();
      end else begin
        exp_q.push_back({ref_mul(a10, b10), ref_mul(a11, b11)});
        rand_ops1();
      end
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (vld0 !== (c == 0)) begin errors++; $display("FAIL cont_vld0[%0d]: got %b want %b", i, vld0, c == 0); end
      checks++; if (vld1 !== (c == 1)) begin errors++; $display("FAIL cont_vld1[%0d]: got %b want %b", i, vld1, c == 1); end
      checks++; if ({p0, p1} !== e) begin errors++; $display("FAIL cont_prod[%0d]: got %h %h want %h %h", i, p0, p1, e[63:32], e[31:0]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy[%0d]: got %b want 1", i, busy); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] e;
    rand_ops0();
    req0 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rmid_gnt0: got %b want 1", gnt0); end
    req0 = 1'b0; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rmid_vld0: got %b want 0", vld0); end
    checks++; if (vld1 !== 1'b0) begin errors++; $display("FAIL rmid_vld1: got %b want 0", vld1); end
    checks++; if (p0 !== 32'h0) begin errors++; $display("FAIL rmid_p0: got %h want 0", p0); end
    checks++; if (p1 !== 32'h0) begin errors++; $display("FAIL rmid_p1: got %h want 0", p1); end
    rand_ops1();
    req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rmid_gnt1: got %b want 1", gnt1); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rmid_vld0_late: got %b want 0", vld0); end
    e = {ref_mul(a10, b10), ref_mul(a11, b11)};
    req1 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (vld1 !== 1'b1) begin errors++; $display("FAIL rmid_vld1_new: got %b want 1", vld1); end
    checks++; if ({p0, p1} !== e) begin errors++; $display("FAIL rmid_prod: got %h %h want %h %h", p0, p1, e[63:32], e[31:0]); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    rand_ops0();
    req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt0[%0d]: got %b want 1", i, gnt0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mul[%0d]: got %b want 1", i, busy); end
      exp_q.push_back({ref_mul(a00, b00), ref_mul(a01, b01)});
      rand_ops0();
      @(posedge clk); @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL b2b_vld0[%0d]: got %b want 1", i, vld0); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_resp[%0d]: got %b want 1", i, busy); end
      checks++; if ({p0, p1} !== e) begin errors++; $display("FAIL b2b_prod[%0d]: got %h %h want %h %h", i, p0, p1, e[63:32], e[31:0]); end
    end
    req0 = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  // Random request mixes; the model only knows "lone requester wins,
  // otherwise the client not granted last wins".
  task automatic test_random();
    logic        r0, r1, w;
    logic [63:0] e;
    apply_reset();
    last_w = 1'b1;
    do begin r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1)); end while (!(r0 || r1));
    rand_ops0(); rand_ops1();
    req0 = r0; req1 = r1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      w = (r0 && r1) ? ~last_w : r1;
      last_w = w;
      e = w ? {ref_mul(a10, b10), ref_mul(a11, b11)} : {ref_mul(a00, b00), ref_mul(a01, b01)};
      checks++; if (gnt0 !== !w) begin errors++; $display("FAIL rnd_gnt0[%0d]: got %b want %b", i, gnt0, !w); end
      checks++; if (gnt1 !== w) begin errors++; $display("FAIL rnd_gnt1[%0d]: got %b want %b", i, gnt1, w); end
      do begin r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1)); end while (!(r0 || r1));
      rand_ops0(); rand_ops1();
      req0 = r0; req1 = r1;
      @(posedge clk); @(negedge clk);
      checks++; if ({vld0, vld1} !== {!w, w}) begin errors++; $display("FAIL rnd_vld[%0d]: got %b%b want %b%b", i, vld0, vld1, !w, w); end
      checks++; if ({p0, p1} !== e) begin errors++; $display("FAIL rnd_prod[%0d]: got %h %h want %h %h", i, p0, p1, e[63:32], e[31:0]); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_sign();
    test_overflow();
    test_contention();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
